dm_store_buffer: RTL and testbench

Posted-write buffer between the CPU memory stage and the data memory (DM). CPU stores are queued in a small FIFO and drained to DM in cycles when no load needs the DM port. Loads go straight to DM, with store-to-load forwarding from the youngest matching queued entry. The CPU then never waits on DM for a store unless the buffer is full.

---
 rtl/dm_store_buffer_if.sv | 37 +++
 rtl/dm_store_buffer.sv | 120 ++++++++++++
 tb/tb_dm_store_buffer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_buffer_if
//  Description : Bundle of CPU-side request/response and DM-side strobe/data
//                signals for the posted-write store buffer.
//                slave  : the store buffer (takes requests, drives the DM port)
//                master : the CPU memory stage plus the data memory model
//  Revision    : 1.0  initial release
// ============================================================================
interface dm_store_buffer_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              cpu_DM_read;
    logic              cpu_DM_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic              DM_read;
    logic              DM_write;
    logic [ADDR_W-1:0] DM_addr;
    logic [DATA_W-1:0] DM_in;
    logic [DATA_W-1:0] DM_out;
    logic              empty;

    modport slave (
        input  cpu_DM_read, cpu_DM_write, cpu_addr, cpu_wdata, DM_out,
        output cpu_rdata, stall, DM_read, DM_write, DM_addr, DM_in, empty
    );

    modport master (
        output cpu_DM_read, cpu_DM_write, cpu_addr, cpu_wdata, DM_out,
        input  cpu_rdata, stall, DM_read, DM_write, DM_addr, DM_in, empty
    );
endinterface
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_buffer
//  Description : Posted-write buffer between the CPU memory stage and the data
//                memory. Stores are queued in a DEPTH-entry FIFO and drained
//                when no load owns the DM port; loads go straight to DM with
//                forwarding from the youngest matching queued store.
//  Ports       : clk, rst (synchronous, active-high)
//                bus (slave): cpu_DM_read/cpu_DM_write/cpu_addr/cpu_wdata in,
//                cpu_rdata/stall out; DM_read/DM_write/DM_addr/DM_in out,
//                DM_out in; empty out.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_store_buffer #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dm_store_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              load_pending;  // previous cycle accepted a load
    logic [DATA_W-1:0] rdata_hold;    // last load result, held between loads

    logic              full;
    logic              both_req;
    logic              load_acc;
    logic              store_acc;
    logic              drain;
    logic              match_hit;
    logic [DATA_W-1:0] match_data;
    logic [DATA_W-1:0] rdata_now;

    assign full      = (count == CNT_W'(DEPTH));
    assign both_req  = bus.cpu_DM_read && bus.cpu_DM_write;
    assign load_acc  = !rst && bus.cpu_DM_read  && !bus.cpu_DM_write && !full;
    assign store_acc = !rst && bus.cpu_DM_write && !bus.cpu_DM_read  && !full;
    // The drain takes the port whenever an accepted load does not; when the
    // buffer is full it wins unconditionally (the load is stalled instead).
    assign drain     = !rst && (count != '0) && (full || !load_acc);

    assign bus.stall    = !rst && (both_req ||
                          ((bus.cpu_DM_read || bus.cpu_DM_write) && full));
    assign bus.DM_read  = load_acc;
    assign bus.DM_write = drain;
    assign bus.DM_addr  = load_acc ? bus.cpu_addr :
                          drain    ? entry_addr[head] : '0;
    assign bus.DM_in    = drain    ? entry_data[head] : '0;
    assign bus.empty    = rst || (count == '0);

    // Load data: in the cycle after acceptance pick forward vs DM, afterwards
    // replay the captured value until the next load completes.
    assign rdata_now     = load_pending ? (fwd_hit ? fwd_data : bus.DM_out)
                                        : rdata_hold;
    assign bus.cpu_rdata = rst ? '0 : rdata_now;

    // Walk valid entries oldest to youngest so the last match wins.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (entry_addr[head + PTR_W'(i)] == bus.cpu_addr)) begin
                match_hit  = 1'b1;
                match_data = entry_data[head + PTR_W'(i)];
            end
        end
    end

    // Entry storage needs no reset: only entries inside [head, head+count)
    // are ever observed.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            entry_addr[tail] <= bus.cpu_addr;
            entry_data[tail] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            fwd_hit      <= 1'b0;
            fwd_data     <= '0;
            load_pending <= 1'b0;
            rdata_hold   <= '0;
        end else begin
            if (store_acc) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            count        <= count + CNT_W'(store_acc) - CNT_W'(drain);
            load_pending <= load_acc;
            if (load_acc) begin
                fwd_hit <= match_hit;
                if (match_hit) begin
                    fwd_data <= match_data;
                end
            end
            if (load_pending) begin
                rdata_hold <= rdata_now;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_store_buffer
//  Description : Self-checking bench for dm_store_buffer. A queue-based model
//                of the store buffer and a word-addressed memory predict every
//                output each cycle; directed steps follow the test plan, then
//                randomized traffic runs against the same model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_store_buffer;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_store_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {17'b0, a} ^ 32'hC0DE_0000;
    endfunction

    // Data memory: registered read, write on strobe.
    logic [DW-1:0] dm_mem [int];
    logic [DW-1:0] dm_out;
    assign bus.DM_out = dm_out;
    always @(posedge clk) begin
        if (bus.DM_read)
            dm_out <= dm_mem.exists(int'(bus.DM_addr)) ? dm_mem[int'(bus.DM_addr)]
                                                       : init_val(bus.DM_addr);
        if (bus.DM_write)
            dm_mem[int'(bus.DM_addr)] = bus.DM_in;
    end

    // Reference model state
    ent_t          q[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_rdata = '0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    // Sampled outputs of the most recent cycle
    logic          s_stall, s_dmr, s_dmw, s_empty;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din, s_rdata;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, advance
    // the model at the edge.
    task automatic cyc(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rs);
        bit            full, la, sa, dr, hit;
        logic [DW-1:0] fwd;
        ent_t          e;
        rst              = rs;
        bus.cpu_DM_read  = r;
        bus.cpu_DM_write = w;
        bus.cpu_addr     = a;
        bus.cpu_wdata    = d;
        full = (q.size() == DEPTH);
        la   = !rs && r && !w && !full;
        sa   = !rs && w && !r && !full;
        dr   = !rs && (q.size() > 0) && (full || !la);
        hit  = 1'b0;
        fwd  = '0;
        foreach (q[i]) if (q[i].a == a) begin hit = 1'b1; fwd = q[i].d; end
        #4;
        s_stall = bus.stall;   s_dmr   = bus.DM_read; s_dmw = bus.DM_write;
        s_addr  = bus.DM_addr; s_din   = bus.DM_in;
        s_rdata = bus.cpu_rdata; s_empty = bus.empty;
        chk("stall",     32'(s_stall), 32'(!rs && ((r && w) || ((r || w) && full))));
        chk("DM_read",   32'(s_dmr),   32'(la));
        chk("DM_write",  32'(s_dmw),   32'(dr));
        chk("DM_addr",   32'(s_addr),  la ? 32'(a) : (dr ? 32'(q[0].a) : 32'd0));
        chk("DM_in",     s_din,        dr ? q[0].d : 32'd0);
        chk("empty",     32'(s_empty), 32'(rs || q.size() == 0));
        chk("cpu_rdata", s_rdata,      rs ? 32'd0 : exp_rdata);
        @(posedge clk);
        if (rs) begin
            q.delete();
            exp_rdata = '0;
        end else begin
            if (la) exp_rdata = hit ? fwd : ref_rd(a);
            if (dr) begin
                ref_mem[int'(q[0].a)] = q[0].d;
                void'(q.pop_front());
            end
            if (sa) begin
                e.a = a; e.d = d;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        bus.cpu_DM_read  = 1'b0;
        bus.cpu_DM_write = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        cyc(1'b1, 1'b0, 15'h7, '0, 1'b1);   // request during reset is ignored
        chk("rst_stall", 32'(s_stall), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);

        // Single store drains the following cycle
        cyc(1'b0, 1'b1, 15'h0010, 32'h1234_5678, 1'b0);
        chk("t1_no_write_enq", 32'(s_dmw), 32'd0);
        idle();
        chk("t1_dm_write", 32'(s_dmw),  32'd1);
        chk("t1_dm_addr",  32'(s_addr), 32'h10);
        chk("t1_dm_in",    s_din,       32'h1234_5678);
        idle();
        chk("t1_empty",    32'(s_empty), 32'd1);

        // Youngest queued store is forwarded
        cyc(1'b0, 1'b1, 15'h5, 32'h11, 1'b0);
        cyc(1'b0, 1'b1, 15'h5, 32'h22, 1'b0);
        cyc(1'b1, 1'b0, 15'h5, '0, 1'b0);
        idle();
        chk("t2_forward", s_rdata, 32'h22);

        // Back-to-back stores drain in order
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 1'b1, AW'(k), 32'hA0 + 32'(k), 1'b0);
            if (k > 1) chk("t3_drain_addr", 32'(s_addr), 32'(k - 1));
        end
        idle();
        chk("t3_last_addr", 32'(s_addr), 32'd5);
        chk("t3_last_data", s_din, 32'hA5);
        idle();
        chk("t3_empty", 32'(s_empty), 32'd1);

        // Loads hold off the drain; non-matching loads read DM
        cyc(1'b0, 1'b1, 15'h30, 32'hBEEF_0030, 1'b0);
        cyc(1'b0, 1'b1, 15'h31, 32'hBEEF_0031, 1'b0);
        cyc(1'b1, 1'b0, 15'h100, '0, 1'b0);
        chk("t4_no_drain", 32'(s_dmw), 32'd0);
        cyc(1'b1, 1'b0, 15'h101, '0, 1'b0);
        chk("t4_dm_data0", s_rdata, init_val(15'h100));
        cyc(1'b1, 1'b0, 15'h30, '0, 1'b0);
        chk("t4_dm_data1", s_rdata, init_val(15'h101));
        idle();
        chk("t4_drain_after", 32'(s_addr), 32'h31);
        chk("t4_old_store",   s_rdata, 32'hBEEF_0030);

        // Both strobes together stall
        cyc(1'b1, 1'b1, 15'h40, 32'h1, 1'b0);
        chk("both_stall", 32'(s_stall), 32'd1);

        // Reset discards the queued store
        cyc(1'b0, 1'b1, 15'h200, 32'hDEAD_0200, 1'b0);
        cyc(1'b0, 1'b1, 15'h201, 32'hDEAD_0201, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        chk("t6_rst_dmw", 32'(s_dmw), 32'd0);
        idle();
        chk("t6_empty", 32'(s_empty), 32'd1);
        chk("t6_dmw",   32'(s_dmw),   32'd0);
        cyc(1'b1, 1'b0, 15'h201, '0, 1'b0);
        idle();
        chk("t6_discarded", s_rdata, init_val(15'h201));

        // Randomized traffic over a small address window to provoke hits
        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            logic        r, w, rs;
            sel = $urandom_range(0, 99);
            r   = (sel < 40) || (sel >= 95);
            w   = (sel >= 40 && sel < 80) || (sel >= 95);
            rs  = ($urandom_range(0, 99) == 0);
            cyc(r, w, AW'($urandom_range(0, 7)), 32'($urandom), rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
